// File: rtl/q_update_if.sv
// Handshake and data bundle between a Q-update requester and q_update_unit.
interface q_update_if;
  logic        start;
  logic [3:0]  action;
  logic [63:0] q_cur;
  logic [63:0] q_next;
  logic [15:0] reward;
  logic        terminal;
  logic [15:0] alpha;
  logic [15:0] gamma;
  logic        busy;
  logic        done;
  logic        err;
  logic        wr_en;
  logic [3:0]  wr_lane;
  logic [15:0] q_new;
  logic [63:0] wr_data;

  modport master (
    output start, action, q_cur, q_next, reward, terminal, alpha, gamma,
    input  busy, done, err, wr_en, wr_lane, q_new, wr_data
  );

  modport slave (
    input  start, action, q_cur, q_next, reward, terminal, alpha, gamma,
    output busy, done, err, wr_en, wr_lane, q_new, wr_data
  );
endinterface

// File: rtl/q_update_unit.sv
// Multi-cycle TD Q-value update: Q(s,a) += alpha*(r + gamma*max Q(s',.) - Q(s,a)).
// Optional macro Q_SAT_EN: saturate target and q_new (otherwise two's-complement wrap).
module q_update_unit (
  input logic      clk,
  input logic      rst_n,
  q_update_if.slave bus
);

  typedef enum logic [2:0] {S_IDLE, S_MAX1, S_MAX2, S_TARGET, S_DELTA, S_STEP} state_t;

  state_t state_q, state_d;

  logic               act_onehot, accept, reject, finish, busy_d;
  logic [3:0]         action_q;
  logic [63:0]        q_cur_q, q_next_q;
  logic signed [15:0] reward_q, q_sa_q, q_sa_sel;
  logic               terminal_q;
  logic [15:0]        alpha_q, gamma_q;

  logic signed [15:0] n0, n1, n2, n3;
  logic signed [15:0] m01_q, m23_q, qmax_q, target_q;
  logic signed [16:0] delta_q;
  logic signed [32:0] g_prod;
  logic signed [16:0] g_val;
  logic signed [18:0] t_sum, qn_sum;
  logic signed [33:0] step_prod;
  logic signed [17:0] step_val;
  logic [15:0]        q_new_d;
  logic [63:0]        wr_data_d;

  logic        busy_q, done_q, err_q, wr_en_q;
  logic [3:0]  wr_lane_q;
  logic [15:0] q_new_q;
  logic [63:0] wr_data_q;

  function automatic logic [15:0] fix16(input logic signed [18:0] v);
`ifdef Q_SAT_EN
    if (v > 19'sd32767)       fix16 = 16'h7FFF;
    else if (v < -19'sd32768) fix16 = 16'h8000;
    else                      fix16 = v[15:0];
`else
    fix16 = 16'(v);
`endif
  endfunction

  assign act_onehot = (bus.action != 4'b0000) && ((bus.action & (bus.action - 4'd1)) == 4'b0000);

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (bus.start && act_onehot) state_d = S_MAX1;
      S_MAX1:   state_d = S_MAX2;
      S_MAX2:   state_d = S_TARGET;
      S_TARGET: state_d = S_DELTA;
      S_DELTA:  state_d = S_STEP;
      S_STEP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    accept = 1'b0;
    reject = 1'b0;
    finish = 1'b0;
    case (state_q)
      S_IDLE: begin
        accept = bus.start && act_onehot;
        reject = bus.start && !act_onehot;
      end
      S_STEP:  finish = 1'b1;
      default: ;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_comb begin
    q_sa_sel = '0;
    for (int i = 0; i < 4; i++)
      if (bus.action[i]) q_sa_sel = bus.q_cur[16*i +: 16];
  end

  assign n0 = q_next_q[15:0];
  assign n1 = q_next_q[31:16];
  assign n2 = q_next_q[47:32];
  assign n3 = q_next_q[63:48];

  // Products keep the full width; arithmetic shift of the full product is floor division.
  assign g_prod    = 33'(qmax_q) * 33'($signed({1'b0, gamma_q}));
  assign g_val     = terminal_q ? 17'sd0 : 17'(g_prod >>> 16);
  assign t_sum     = 19'(reward_q) + 19'(g_val);
  assign step_prod = 34'(delta_q) * 34'($signed({1'b0, alpha_q}));
  assign step_val  = 18'(step_prod >>> 16);
  assign qn_sum    = 19'(q_sa_q) + 19'(step_val);
  assign q_new_d   = fix16(qn_sum);

  always_comb begin
    wr_data_d = q_cur_q;
    for (int i = 0; i < 4; i++)
      if (action_q[i]) wr_data_d[16*i +: 16] = q_new_d;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      action_q   <= bus.action;
      q_cur_q    <= bus.q_cur;
      q_next_q   <= bus.q_next;
      reward_q   <= bus.reward;
      terminal_q <= bus.terminal;
      alpha_q    <= bus.alpha;
      gamma_q    <= bus.gamma;
      q_sa_q     <= q_sa_sel;
    end
    if (state_q == S_MAX1) begin
      m01_q <= (n0 > n1) ? n0 : n1;
      m23_q <= (n2 > n3) ? n2 : n3;
    end
    if (state_q == S_MAX2)   qmax_q   <= (m01_q > m23_q) ? m01_q : m23_q;
    if (state_q == S_TARGET) target_q <= fix16(t_sum);
    if (state_q == S_DELTA)  delta_q  <= 17'(target_q) - 17'(q_sa_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_lane_q <= '0;
      q_new_q   <= '0;
      wr_data_q <= '0;
    end else begin
      busy_q  <= busy_d;
      done_q  <= finish;
      wr_en_q <= finish;
      err_q   <= reject;
      if (finish) begin
        wr_lane_q <= action_q;
        q_new_q   <= q_new_d;
        wr_data_q <= wr_data_d;
      end
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.err     = err_q;
  assign bus.wr_en   = wr_en_q;
  assign bus.wr_lane = wr_lane_q;
  assign bus.q_new   = q_new_q;
  assign bus.wr_data = wr_data_q;

endmodule

// File: tb/tb_q_update_unit.sv
// Self-checking bench for q_update_unit: directed cases, random updates against an arithmetic model.
module tb_q_update_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;

  q_update_if bus ();

  q_update_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic longint fdiv(input longint a);
    longint q;
    q = a / 65536;
    if (a < 0 && q * 65536 != a) q = q - 1;
    return q;
  endfunction

  function automatic longint fit16(input longint v);
`ifdef Q_SAT_EN
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
`else
    longint w;
    w = v % 65536;
    if (w < 0) w = w + 65536;
    if (w > 32767) w = w - 65536;
    return w;
`endif
  endfunction

  function automatic logic [15:0] model_q(input logic [63:0] qc, input logic [63:0] qn,
                                          input logic [3:0] act, input logic [15:0] r,
                                          input logic term, input logic [15:0] al,
                                          input logic [15:0] ga);
    longint qmax, lane_v, qsa, g, t, delta, step, res;
    logic [15:0] out;
    qmax = -100000;
    qsa = 0;
    for (int i = 0; i < 4; i++) begin
      lane_v = longint'($signed(qn[16*i +: 16]));
      if (lane_v > qmax) qmax = lane_v;
      if (act[i]) qsa = longint'($signed(qc[16*i +: 16]));
    end
    g = term ? 0 : fdiv(qmax * longint'(ga));
    t = fit16(longint'($signed(r)) + g);
    delta = t - qsa;
    step = fdiv(delta * longint'(al));
    res = fit16(qsa + step);
    out = res[15:0];
    return out;
  endfunction

  task automatic drive(input logic [63:0] qc, input logic [63:0] qn, input logic [3:0] act,
                       input logic [15:0] r, input logic term, input logic [15:0] al,
                       input logic [15:0] ga);
    bus.q_cur = qc;
    bus.q_next = qn;
    bus.action = act;
    bus.reward = r;
    bus.terminal = term;
    bus.alpha = al;
    bus.gamma = ga;
  endtask

  task automatic scramble();
    bus.q_cur = {$urandom, $urandom};
    bus.q_next = {$urandom, $urandom};
    bus.action = 4'($urandom);
    bus.reward = 16'($urandom);
    bus.terminal = 1'($urandom);
    bus.alpha = 16'($urandom);
    bus.gamma = 16'($urandom);
  endtask

  // One full update from idle; inputs are scrambled right after acceptance.
  task automatic run_txn(input logic [63:0] qc, input logic [63:0] qn, input logic [3:0] act,
                         input logic [15:0] r, input logic term, input logic [15:0] al,
                         input logic [15:0] ga, input string tag, output logic [15:0] q_obs);
    logic [15:0] exp_q;
    logic [63:0] exp_data;
    int wr_at, wr_cnt, err_cnt, busy_bad;
    logic done_at, busy_at;
    logic [15:0] q_at, q_hold;
    logic [63:0] d_at;
    logic [3:0]  l_at;
    logic wr_hold;
    exp_q = model_q(qc, qn, act, r, term, al, ga);
    exp_data = qc;
    for (int i = 0; i < 4; i++) if (act[i]) exp_data[16*i +: 16] = exp_q;
    wr_at = -1; wr_cnt = 0; err_cnt = 0; busy_bad = 0;
    done_at = 0; busy_at = 1; q_at = '0; d_at = '0; l_at = '0; q_hold = '0; wr_hold = 1;
    drive(qc, qn, act, r, term, al, ga);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    scramble();
    checks++;
    if (bus.busy !== 1'b1) begin failures++; $display("FAIL %s busy_after_accept got=%b exp=1", tag, bus.busy); end
    for (int k = 1; k <= 8; k++) begin
      if (k == 2) begin bus.start = 1'b1; bus.action = 4'b0011; end
      if (k == 3) bus.start = 1'b0;
      @(posedge clk); #1;
      if (bus.err) err_cnt++;
      if (k < 5 && bus.busy !== 1'b1) busy_bad++;
      if (bus.wr_en) begin
        wr_cnt++;
        if (wr_at < 0) begin
          wr_at = k; done_at = bus.done; busy_at = bus.busy;
          q_at = bus.q_new; d_at = bus.wr_data; l_at = bus.wr_lane;
        end
      end
      if (k == 6) begin q_hold = bus.q_new; wr_hold = bus.wr_en; end
    end
    checks++;
    if (wr_at != 5) begin failures++; $display("FAIL %s latency got=%0d exp=5", tag, wr_at); end
    checks++;
    if (wr_cnt != 1) begin failures++; $display("FAIL %s wr_en_count got=%0d exp=1", tag, wr_cnt); end
    checks++;
    if (done_at !== 1'b1 || busy_at !== 1'b0) begin
      failures++; $display("FAIL %s done_busy_at_write got=%b%b exp=10", tag, done_at, busy_at);
    end
    checks++;
    if (busy_bad != 0) begin failures++; $display("FAIL %s busy_dropped got=%0d exp=0", tag, busy_bad); end
    checks++;
    if (err_cnt != 0) begin failures++; $display("FAIL %s err_while_busy got=%0d exp=0", tag, err_cnt); end
    checks++;
    if (q_at !== exp_q) begin failures++; $display("FAIL %s q_new got=%h exp=%h", tag, q_at, exp_q); end
    checks++;
    if (d_at !== exp_data) begin failures++; $display("FAIL %s wr_data got=%h exp=%h", tag, d_at, exp_data); end
    checks++;
    if (l_at !== act) begin failures++; $display("FAIL %s wr_lane got=%b exp=%b", tag, l_at, act); end
    checks++;
    if (q_hold !== exp_q || wr_hold !== 1'b0) begin
      failures++; $display("FAIL %s hold got=%h/%b exp=%h/0", tag, q_hold, wr_hold, exp_q);
    end
    q_obs = q_at;
  endtask

  task automatic test_reset();
    bus.start = 1'b0;
    drive('0, '0, 4'b0001, '0, 1'b0, '0, '0);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.err, bus.wr_en} !== 4'b0000 || bus.wr_lane !== 4'b0
        || bus.q_new !== 16'h0 || bus.wr_data !== 64'h0) begin
      failures++;
      $display("FAIL reset_state got=%b%b%b%b lane=%b q=%h d=%h exp=all0", bus.busy, bus.done,
               bus.err, bus.wr_en, bus.wr_lane, bus.q_new, bus.wr_data);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [15:0] q;
    logic [63:0] qn_nom;
    qn_nom = {16'h0100, 16'hFF00, 16'h0000, 16'h0200};
    run_txn(64'h0, qn_nom, 4'b0001, 16'h0100, 1'b0, 16'h8000, 16'h8000, "nominal", q);
    checks++;
    if (q !== 16'h0100) begin failures++; $display("FAIL nominal_const got=%h exp=0100", q); end
    run_txn(64'h0, qn_nom, 4'b0001, 16'h0100, 1'b1, 16'h8000, 16'h8000, "terminal", q);
    checks++;
    if (q !== 16'h0080) begin failures++; $display("FAIL terminal_const got=%h exp=0080", q); end
    run_txn(64'h0000_7F00_0000_0000, {16'h0000, 16'h4000, 16'h0000, 16'h0000}, 4'b0100,
            16'h7FFF, 1'b0, 16'h8000, 16'h8000, "saturate", q);
    checks++;
`ifdef Q_SAT_EN
    if (q !== 16'h7F7F) begin failures++; $display("FAIL saturate_const got=%h exp=7F7F", q); end
`else
    if (q !== 16'h0F7F) begin failures++; $display("FAIL saturate_const got=%h exp=0F7F", q); end
`endif
    run_txn(64'h0000_0000_0000_0001, {$urandom, $urandom}, 4'b0001, 16'h0000, 1'b1,
            16'h8000, 16'h8000, "floor", q);
    checks++;
    if (q !== 16'h0000) begin failures++; $display("FAIL floor_const got=%h exp=0000", q); end
  endtask

  function automatic logic [15:0] rand_lane();
    case ($urandom_range(0, 5))
      0: return 16'h7FFF;
      1: return 16'h8000;
      2: return 16'(16'($urandom_range(0, 7)) - 16'd3);
      default: return 16'($urandom);
    endcase
  endfunction

  function automatic logic [15:0] rand_coef();
    case ($urandom_range(0, 4))
      0: return 16'hFFFF;
      1: return 16'h0000;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic test_random();
    logic [15:0] q;
    logic [63:0] qc, qn;
    logic [3:0] act;
    for (int n = 0; n < 30; n++) begin
      qc = {rand_lane(), rand_lane(), rand_lane(), rand_lane()};
      qn = {rand_lane(), rand_lane(), rand_lane(), rand_lane()};
      act = 4'b0001 << $urandom_range(0, 3);
      run_txn(qc, qn, act, rand_lane(), 1'($urandom_range(0, 3) == 0), rand_coef(), rand_coef(),
              "random", q);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
  endtask

  task automatic test_err();
    logic [3:0] bad [3];
    int wr_seen;
    bad[0] = 4'b0011;
    bad[1] = 4'b0000;
    bad[2] = 4'b1111;
    for (int n = 0; n < 3; n++) begin
      wr_seen = 0;
      bus.action = bad[n];
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      checks++;
      if (bus.err !== 1'b1 || bus.busy !== 1'b0) begin
        failures++; $display("FAIL err_pulse act=%b got=err%b busy%b exp=err1 busy0", bad[n], bus.err, bus.busy);
      end
      @(posedge clk); #1;
      checks++;
      if (bus.err !== 1'b0) begin failures++; $display("FAIL err_one_cycle got=%b exp=0", bus.err); end
      for (int k = 0; k < 7; k++) begin
        if (bus.wr_en || bus.busy) wr_seen++;
        @(posedge clk); #1;
      end
      checks++;
      if (wr_seen != 0) begin failures++; $display("FAIL err_no_activity got=%0d exp=0", wr_seen); end
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] qc, qn;
    logic [15:0] r, al, ga, exp_q;
    int wr_edges [$];
    int bad_q;
    qc = {$urandom, $urandom};
    qn = {$urandom, $urandom};
    r = 16'($urandom); al = 16'($urandom); ga = 16'($urandom);
    exp_q = model_q(qc, qn, 4'b0010, r, 1'b0, al, ga);
    bad_q = 0;
    drive(qc, qn, 4'b0010, r, 1'b0, al, ga);
    bus.start = 1'b1;
    for (int e = 0; e < 20; e++) begin
      @(posedge clk); #1;
      if (e == 11) bus.start = 1'b0;
      if (bus.wr_en) begin
        wr_edges.push_back(e);
        if (bus.q_new !== exp_q) bad_q++;
      end
    end
    checks++;
    if (wr_edges.size() != 2) begin
      failures++; $display("FAIL b2b_count got=%0d exp=2", wr_edges.size());
    end else begin
      checks++;
      if (wr_edges[0] != 5 || wr_edges[1] != 11) begin
        failures++; $display("FAIL b2b_spacing got=%0d,%0d exp=5,11", wr_edges[0], wr_edges[1]);
      end
    end
    checks++;
    if (bad_q != 0) begin failures++; $display("FAIL b2b_q_new got=%0d_bad exp=0_bad", bad_q); end
  endtask

  task automatic test_reset_midflight();
    logic [15:0] q;
    int wr_seen;
    wr_seen = 0;
    drive({$urandom, $urandom}, {$urandom, $urandom}, 4'b1000, 16'($urandom), 1'b0, 16'hC000, 16'h4000);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({bus.busy, bus.done, bus.err, bus.wr_en} !== 4'b0000 || bus.wr_lane !== 4'b0
        || bus.q_new !== 16'h0 || bus.wr_data !== 64'h0) begin
      failures++;
      $display("FAIL midflight_reset got=%b%b%b%b lane=%b q=%h d=%h exp=all0", bus.busy, bus.done,
               bus.err, bus.wr_en, bus.wr_lane, bus.q_new, bus.wr_data);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (bus.wr_en || bus.busy) wr_seen++;
    end
    checks++;
    if (wr_seen != 0) begin failures++; $display("FAIL midflight_no_write got=%0d exp=0", wr_seen); end
    run_txn({$urandom, $urandom}, {$urandom, $urandom}, 4'b0100, 16'($urandom), 1'b0,
            16'($urandom), 16'($urandom), "after_reset", q);
  endtask

  initial begin
    bus.start = 1'b0;
    drive('0, '0, '0, '0, 1'b0, '0, '0);
    test_reset();
    test_directed();
    test_err();
    test_random();
    test_back_to_back();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/q_update_unit.md
# q_update_unit

Temporal-difference Q-value update stage that sits downstream of the policy generator. It consumes the action the policy generator selected, the current-state Q row it chose from, the next-state Q row and the environment reward. It computes Q(s,a) ← Q(s,a) + α·(r + γ·maxₐ′Q(s′,a′) − Q(s,a)) through a multi-cycle FSM and emits a one-cycle write of the updated row back to the Q table.

## Interface
Parameters: none (widths fixed by the Q-table format: 4 actions × 16-bit Q per row).

- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  request pulse; sampled only in IDLE
- action  in  4  one-hot selected action; bit i ↔ lane i
- q_cur  in  64  Q row of current state; lane i = bits [16i+15:16i], signed Q8.8
- q_next  in  64  Q row of next state, same format
- reward  in  16  signed Q8.8
- terminal  in  1  next state terminal; γ term forced to 0
- alpha  in  16  unsigned Q0.16 learning rate (value/65536)
- gamma  in  16  unsigned Q0.16 discount
- busy  out  1  update in progress
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle pulse: start rejected, action not one-hot
- wr_en  out  1  one-cycle Q-table write strobe, coincident with done
- wr_lane  out  4  one-hot lane written (= captured action)
- q_new  out  16  updated Q(s,a), signed Q8.8
- wr_data  out  64  q_cur with lane a replaced by q_new

## Operation
- All inputs captured into internal registers on the accepting edge; inputs may change afterwards.
- FSM: IDLE → MAX1 → MAX2 → TARGET → DELTA → STEP → IDLE.
- IDLE: start=1 with one-hot action → capture, busy←1, go MAX1. start=1 with non-one-hot action → err←1 for one cycle, stay IDLE, nothing captured.
- MAX1: m01=max(lane0,lane1), m23=max(lane2,lane3) of q_next (signed compare).
- MAX2: qmax=max(m01,m23).
- TARGET: g = (qmax × gamma) >>> 16 (32-bit signed×unsigned product, arithmetic shift, floor). If terminal, g=0. target = sat16(reward + g).
- DELTA: delta = target − q_sa, 17-bit signed, never truncated. q_sa is the q_cur lane selected by action.
- STEP: step = (delta × alpha) >>> 16, floor. q_new = sat16(q_sa + step). Register q_new, wr_data, wr_lane; wr_en←1, done←1, busy←0; go IDLE.
- sat16 clamps to 0x7FFF / 0x8000.
- Reset values: busy, done, err, wr_en = 0; wr_lane = 0; q_new = 0; wr_data = 0.
- q_new, wr_data and wr_lane hold their values until the next completion or reset.

## Timing
- Sampling edge E0 (start accepted) → wr_en/done high in the cycle after E5, deasserted at E6. Latency: 5 cycles.
- busy high from after E0 until E5; low in the same cycle done is high.
- start while busy: ignored, no err.
- start in the cycle done is high: accepted (FSM is in IDLE), so back-to-back updates run every 6 cycles.
- rst_n low at any edge: FSM → IDLE, all outputs to reset values, in-flight update discarded with no write.
- err is a one-cycle pulse asserted the cycle after the rejecting edge.

## Configuration
- Q_SAT_EN defined: sat16 applied to target and q_new as above.
- Q_SAT_EN undefined: target and q_new are truncated to 16 bits (two's-complement wrap). delta stays 17-bit in both builds.

## Test plan
- Nominal: q_cur=0, action=4'b0001, reward=0x0100, q_next lanes {0x0200,0x0000,0xFF00,0x0100}, gamma=0x8000, alpha=0x8000 → after 5 cycles wr_en=done=1 for 1 cycle, q_new=0x0100, wr_lane=0001, wr_data=0x0000_0000_0000_0100.
- Terminal: same as nominal with terminal=1 → q_new=0x0080.
- Saturation: action=4'b0100, q_cur lane2=0x7F00, reward=0x7FFF, q_next max 0x4000, gamma=0x8000, alpha=0x8000 → with Q_SAT_EN q_new=0x7F7F; without it q_new=0x0F7F.
- Floor rounding: delta=−1 LSB (q_sa=0x0001, reward=0, terminal=1), alpha=0x8000 → step=−1, q_new=0x0000.
- Handshake: start held high for 12 cycles with valid action → exactly two completions, 6 cycles apart. start with action=4'b0011 → err pulse, busy stays 0, no wr_en.
- Reset: rst_n=0 at E3 → next cycle all outputs 0, no wr_en ever issued for that request. A new start afterwards completes normally.
